// File: rtl/hex_entry_buffer_if.sv
// Event/entry bus between the switch-input decoder and the hex entry buffer.
interface hex_entry_buffer_if;
  logic [3:0]  hex;
  logic        pulse;
  logic        del;
  logic        clr;
  logic [31:0] value;
  logic [3:0]  count;
  logic        full;
  logic        ovf;
  logic [3:0]  seg_data;
  logic [2:0]  seg_an;

  modport master (
    output hex, pulse, del, clr,
    input  value, count, full, ovf, seg_data, seg_an
  );

  modport slave (
    input  hex, pulse, del, clr,
    output value, count, full, ovf, seg_data, seg_an
  );
endinterface

// File: rtl/hex_entry_buffer.sv
// Eight-digit hex entry register with backspace/clear and a multiplexed 7-segment scan.
module hex_entry_buffer #(
  parameter int unsigned SCAN_DIV = 250000
) (
  input logic              clk,
  input logic              rst,
  hex_entry_buffer_if.slave bus
);

  localparam int unsigned DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned MAX_DIGIT = 8;

  logic [31:0]      value_q, value_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       seg_an_q;
  logic [31:0]      value_shift;

  // Entry update: clr beats del beats pulse; one action per cycle.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.clr) begin
      value_d = '0;
      count_d = '0;
    end else if (bus.del) begin
      if (count_q != 4'd0) begin
        value_d = {4'h0, value_q[31:4]};
        count_d = count_q - 4'd1;
      end
    end else if (bus.pulse) begin
      if (count_q < 4'(MAX_DIGIT)) begin
        value_d = {value_q[27:0], bus.hex};
        count_d = count_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display scan: hold each digit index for SCAN_DIV cycles, free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      seg_an_q <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt  <= '0;
      seg_an_q <= seg_an_q + 3'd1;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Digit select into the live value, so seg_data tracks value with no lag.
  assign value_shift  = value_q >> {seg_an_q, 2'b00};
  assign bus.seg_data = value_shift[3:0];

  assign bus.value  = value_q;
  assign bus.count  = count_q;
  assign bus.full   = (count_q == 4'(MAX_DIGIT));
  assign bus.ovf    = ovf_q;
  assign bus.seg_an = seg_an_q;

endmodule

// File: tb/tb_hex_entry_buffer.sv
// Bench for hex_entry_buffer: digit-queue model checked every cycle plus literal expectations.
module tb_hex_entry_buffer;

  localparam int unsigned SD = 4;

  logic clk;
  logic rst;
  hex_entry_buffer_if bus ();

  hex_entry_buffer #(.SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Model: digits held oldest-first; scan position from edges since reset.
  logic [3:0] q[$];
  int         cyc = 0;
  logic       exp_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_value();
    logic [31:0] v = 32'h0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  function automatic logic [2:0] model_an();
    return 3'((cyc / SD) % 8);
  endfunction

  function automatic logic [3:0] model_seg();
    int idx = int'(model_an());
    if (idx < q.size()) return q[q.size() - 1 - idx];
    return 4'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("value",    bus.value,           model_value());
      chk("count",    32'(bus.count),      32'(q.size()));
      chk("full",     32'(bus.full),       32'(q.size() == 8));
      chk("ovf",      32'(bus.ovf),        32'(exp_ovf));
      chk("seg_an",   32'(bus.seg_an),     32'(model_an()));
      chk("seg_data", 32'(bus.seg_data),   32'(model_seg()));
    end
  end

  task automatic step(input logic r, input logic p, input logic d, input logic c, input logic [3:0] h);
    rst       = r;
    bus.pulse = p;
    bus.del   = d;
    bus.clr   = c;
    bus.hex   = h;
    @(posedge clk);
    if (r) begin
      q.delete();
      cyc     = 0;
      exp_ovf = 1'b0;
    end else begin
      cyc++;
      exp_ovf = 1'b0;
      if (c) q.delete();
      else if (d) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (p) begin
        if (q.size() < 8) q.push_back(h);
        else exp_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic push(input logic [3:0] h);
    step(1'b0, 1'b1, 1'b0, 1'b0, h);
  endtask

  initial begin
    rst = 1'b1;
    bus.pulse = 1'b0; bus.del = 1'b0; bus.clr = 1'b0; bus.hex = 4'h0;

    // Reset held two cycles with a pulse present
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    check_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    chk("rst_value",  bus.value,        32'h0);
    chk("rst_count",  32'(bus.count),   32'd0);
    chk("rst_full",   32'(bus.full),    32'd0);
    chk("rst_ovf",    32'(bus.ovf),     32'd0);
    chk("rst_seg_an", 32'(bus.seg_an),  32'd0);
    idle();
    chk("post_rst_value", bus.value, 32'h0);

    // Append 1,2,3 back to back
    push(4'h1); chk("app1", bus.value, 32'h0000_0001);
    push(4'h2); chk("app2", bus.value, 32'h0000_0012);
    push(4'h3); chk("app3", bus.value, 32'h0000_0123);
    chk("app3_count", 32'(bus.count), 32'd3);

    // Backspace down to empty, then one more on empty
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("del1", bus.value, 32'h0000_0012);
    chk("del1_count", 32'(bus.count), 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("del_empty", bus.value, 32'h0);
    chk("del_empty_count", 32'(bus.count), 32'd0);

    // Fill with 1..8 then overflow with 9
    for (int i = 1; i <= 8; i++) push(4'(i));
    chk("fill", bus.value, 32'h1234_5678);
    chk("fill_full", 32'(bus.full), 32'd1);
    push(4'h9);
    chk("ovf_value", bus.value, 32'h1234_5678);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    idle();
    chk("ovf_clear", 32'(bus.ovf), 32'd0);

    // Priority: clr wins over del and pulse, also when full
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    chk("prio_full_ovf", 32'(bus.ovf), 32'd0);
    push(4'h1); push(4'h2); push(4'h3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    chk("prio_clr_value", bus.value, 32'h0);
    chk("prio_clr_count", 32'(bus.count), 32'd0);
    chk("prio_clr_ovf", 32'(bus.ovf), 32'd0);
    push(4'h4); push(4'h5);
    chk("prio_45", bus.value, 32'h0000_0045);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
    chk("prio_del", bus.value, 32'h0000_0004);
    chk("prio_del_count", 32'(bus.count), 32'd1);

    // Leading zero counts as a digit
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    push(4'h0);
    chk("zero_count", 32'(bus.count), 32'd1);

    // Scan over 87654321; one dropped pulse mid-scan
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 8; i >= 1; i--) push(4'(i));
    chk("scan_value", bus.value, 32'h8765_4321);
    for (int i = 0; i < 40; i++) begin
      if (i == 13) push(4'hF);
      else idle();
      chk("scan_digit", 32'(bus.seg_data), 32'(bus.seg_an) + 32'd1);
    end

    // Scan restarts from reset: first advance SD cycles later
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 1; i < SD; i++) idle();
    chk("scan_hold", 32'(bus.seg_an), 32'd0);
    idle();
    chk("scan_adv", 32'(bus.seg_an), 32'd1);

    idle();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_entry_buffer.md
# hex_entry_buffer

Consumer side of the switch-input event interface: accepts one-cycle `pulse` strobes carrying a 4-bit `hex` code and assembles them into an 8-digit hexadecimal entry register. It also supports backspace and clear, and drives the board's time-multiplexed 7-segment display (4-bit data, 3-bit digit select) with the current entry. It sits between the switch-input decoder and the display/output logic of the lab top level.

## Interface
- `SCAN_DIV`, default 250000: clock cycles each digit is held on the display before advancing (400 Hz per digit at 100 MHz); legal range 2..2^20.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `hex`  in  4  digit code accompanying `pulse`; ignored when `pulse`=0.
- `pulse`  in  1  one-cycle strobe: append `hex` as a new least-significant digit.
- `del`  in  1  one-cycle strobe: remove the least-significant digit (backspace).
- `clr`  in  1  one-cycle strobe: empty the buffer.
- `value`  out  32  entered digits, most recent in [3:0], unused upper digits 0.
- `count`  out  4  number of digits entered, 0..8.
- `full`  out  1  `count`==8.
- `ovf`  out  1  one-cycle flag: a `pulse` was dropped because the buffer was full.
- `seg_data`  out  4  nibble of `value` for the currently selected digit.
- `seg_an`  out  3  currently selected digit index, 0 = rightmost ([3:0]).

## Operation
- Registers: `value`[31:0], `count`[3:0], `ovf`, scan divider `div_cnt` (ceil(log2(SCAN_DIV)) bits), `seg_an`[2:0].
- Reset (`rst`=1 at an edge): `value`=0, `count`=0, `ovf`=0, `div_cnt`=0, `seg_an`=0. This gives `full`=0 and `seg_data`=0. Reset overrides every other input and aborts any operation in flight.
- Entry update, per edge, in priority order `clr` > `del` > `pulse`. At most one action per cycle; lower-priority strobes in the same cycle are discarded, not queued.
  - `clr`: `value`=0, `count`=0.
  - `del` with `count`>0: `value` = {4'h0, `value`[31:4]}, `count`-1.
  - `del` with `count`=0: no change.
  - `pulse` with `count`<8: `value` = {`value`[27:0], `hex`}, `count`+1.
  - `pulse` with `count`=8: no change; `ovf`=1 for the following cycle.
- `ovf` is 0 in every cycle not produced by a dropped `pulse`. It is also 0 when the dropped `pulse` lost to `clr` or `del`.
- All 16 `hex` codes, including 0, are appended as data. A leading 0 still counts toward `count`.
- `full` = (`count`==8), combinational from the register.
- Scan:
  - `div_cnt` increments every cycle.
  - When `div_cnt`==SCAN_DIV-1, it wraps to 0 and `seg_an` increments modulo 8 (7→0).
  - Scanning is independent of entry activity; only `rst` resets it.
- `seg_data` = `value`[4*`seg_an`+3 : 4*`seg_an`], combinational from the registered `value` and `seg_an`.

## Timing
- Strobes are sampled at rising edge N. `value` and `count` reflect the action after edge N, so they are valid in cycle N+1. Latency is 1 cycle.
- `ovf` is asserted for exactly cycle N+1 after a dropped `pulse` at edge N.
- Back-to-back `pulse` on consecutive cycles is legal; each is accepted. Throughput is 1 digit/cycle.
- `seg_data` follows a `value` change in the same cycle that `value` updates, with no extra delay.
- `seg_an` holds each index for exactly SCAN_DIV cycles. A full 8-digit scan period is 8·SCAN_DIV cycles.
- After reset is released, the first `seg_an` advance occurs SCAN_DIV cycles later.
- `pulse` held high for k cycles is treated as k append events. The upstream block guarantees single-cycle strobes.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `pulse`=1, `hex`=5 → after release `value`=0, `count`=0, `full`=0, `ovf`=0, `seg_an`=0.
- **Append:** pulses with hex 1,2,3 on consecutive cycles → `value`=32'h0000_0123, `count`=3, each update visible 1 cycle after its strobe.
- **Fill and overflow:** append 8 digits 1..8 → `value`=32'h1234_5678, `full`=1. A 9th `pulse` with hex 9 → `value` unchanged, `ovf`=1 for one cycle, then 0.
- **Backspace:** from 32'h0000_0123, `del` → 32'h0000_0012, `count`=2. Three more `del` → `value`=0, `count`=0, and the extra `del` on empty causes no change.
- **Priority:** from `count`=3, `clr`, `del` and `pulse` (hex A) in the same cycle → `value`=0, `count`=0, `ovf`=0. Then `del`+`pulse` together on 32'h0000_0045 → 32'h0000_0004, `count`=1.
- **Scan:** with SCAN_DIV=4 and `value`=32'h8765_4321:
  - `seg_an` steps 0..7 every 4 cycles and wraps to 0 after 32 cycles.
  - `seg_data` reads 1,2,…,8 in step with `seg_an`.
  - A `pulse` mid-scan does not disturb `seg_an` timing.
